// File: rtl/cpu6502_pkg.sv
// rtl/cpu6502_pkg.sv - shared 6502 core constants and types
package cpu6502_pkg;

    localparam int TCU_W = 4;
    localparam logic [TCU_W-1:0] TCU_MAX = 4'd7;
    localparam logic [7:0] OP_BRK = 8'h00;

    typedef enum logic [1:0] {
        INT_BRK   = 2'd0,
        INT_IRQ   = 2'd1,
        INT_NMI   = 2'd2,
        INT_RESET = 2'd3
    } int_src_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// rtl/instruction_sequencer_if.sv - sequencer bus and decoder-facing signals
interface instruction_sequencer_if;
    import cpu6502_pkg::*;

    logic             i_rdy;
    logic [7:0]       i_data;
    logic [TCU_W-1:0] i_tcu_next;
    logic             i_irq_n;
    logic             i_nmi_n;
    logic             i_p_i;
    logic [7:0]       o_ir;
    logic [TCU_W-1:0] o_tcu;
    logic             o_sync;
    int_src_t         o_int_src;
    logic             o_runaway;

    modport master (
        output i_rdy, i_data, i_tcu_next, i_irq_n, i_nmi_n, i_p_i,
        input  o_ir, o_tcu, o_sync, o_int_src, o_runaway
    );

    modport slave (
        input  i_rdy, i_data, i_tcu_next, i_irq_n, i_nmi_n, i_p_i,
        output o_ir, o_tcu, o_sync, o_int_src, o_runaway
    );

endinterface

// File: rtl/nmi_edge_detector.sv
// rtl/nmi_edge_detector.sv - latches NMI falling edges until serviced
module nmi_edge_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic nmi_n,
    input  logic service,
    output logic pending
);

    logic nmi_prev;
    logic nmi_pending;

    // A new edge wins over a same-cycle service so it is not lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            nmi_prev    <= 1'b1;
            nmi_pending <= 1'b0;
        end else begin
            nmi_prev <= nmi_n;
            if (nmi_prev && !nmi_n) begin
                nmi_pending <= 1'b1;
            end else if (service) begin
                nmi_pending <= 1'b0;
            end
        end
    end

    assign pending = nmi_pending;

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - 6502 IR and timing counter feeding the decoder
module instruction_sequencer
    import cpu6502_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    instruction_sequencer_if.slave  bus
);

    logic [7:0]       ir_q, ir_d;
    logic [TCU_W-1:0] tcu_q, tcu_d;
    int_src_t         int_src_q, int_src_d;
    logic             runaway_q, runaway_d;
    logic             nmi_pending;
    logic             nmi_service;
    logic             fetch;

    assign fetch       = bus.i_rdy && (tcu_q == '0);
    assign nmi_service = fetch && nmi_pending;

    nmi_edge_detector u_nmi (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .nmi_n   (bus.i_nmi_n),
        .service (nmi_service),
        .pending (nmi_pending)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ir_q      <= OP_BRK;
            tcu_q     <= TCU_W'(1);
            int_src_q <= INT_RESET;
            runaway_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            tcu_q     <= tcu_d;
            int_src_q <= int_src_d;
            runaway_q <= runaway_d;
        end
    end

    always_comb begin
        ir_d      = ir_q;
        tcu_d     = tcu_q;
        int_src_d = int_src_q;
        runaway_d = runaway_q;
        if (fetch) begin
            tcu_d = TCU_W'(1);
            if (nmi_pending) begin
                ir_d      = OP_BRK;
                int_src_d = INT_NMI;
            end else if (!bus.i_irq_n && !bus.i_p_i) begin
                ir_d      = OP_BRK;
                int_src_d = INT_IRQ;
            end else begin
                ir_d      = bus.i_data;
                int_src_d = INT_BRK;
            end
        end else if (bus.i_rdy) begin
            // Out-of-range requests are trapped to T0 rather than wrapping.
            if (bus.i_tcu_next > TCU_MAX) begin
                tcu_d     = '0;
                runaway_d = 1'b1;
            end else begin
                tcu_d = bus.i_tcu_next;
            end
        end
    end

    assign bus.o_ir      = ir_q;
    assign bus.o_tcu     = tcu_q;
    assign bus.o_int_src = int_src_q;
    assign bus.o_runaway = runaway_q;
    assign bus.o_sync    = (tcu_q == '0);

endmodule
